sc_backg_lane_datapath: RTL

- Datapath responder driven by the background lane control FSM in the Frogger design.
- Consumes the FSM's clear, load, shift-select, count-enable and last-register strobes.
- Holds one background lane pattern in a rotating register and keeps a snapshot of it in a last-register.
- Runs the lane-speed timer and returns the active-low tick T0 back to the FSM, which uses it to decide when to shift.

---
 rtl/sc_backg_lane_datapath.sv | 105 ++++++++++
 1 files changed

// File: rtl/sc_backg_lane_datapath.sv
// Background lane datapath for the Frogger lane FSM. It holds a rotating lane pattern and a snapshot register,
// and it runs the lane-speed timer whose active-low tick T0 tells the FSM when to shift.
module sc_backg_lane_datapath #(
  parameter int                   DATAWIDTH    = 8,
  parameter int                   COUNT_WIDTH  = 23,
  parameter int                   COUNT_LIMIT  = 2500000,
  parameter logic [DATAWIDTH-1:0] INIT_PATTERN = 8'b11000011
) (
  input  logic                 SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic                 SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic                 clear_InLow,
  input  logic                 load_InLow,
  input  logic [1:0]           shiftselection_In,
  input  logic                 upcount_InLow,
  input  logic                 loadLastRegister_InLow,
  input  logic [DATAWIDTH-1:0] data_In,
  output logic [DATAWIDTH-1:0] lane_Out,
  output logic [DATAWIDTH-1:0] lastRegister_Out,
  output logic                 T0_OutLow
);

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(COUNT_LIMIT - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic {
    T0_PENDING = 1'b0,
    T0_IDLE    = 1'b1
  } t0_state_e;

  logic [DATAWIDTH-1:0]   lane_q, lane_d;
  logic [DATAWIDTH-1:0]   last_q, last_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  t0_state_e              t0_q, t0_d;
  logic                   terminal;
  logic                   shift_done;

  // A shift only counts as consuming the tick when clear and load have not overridden it.
  assign shift_done = clear_InLow && load_InLow &&
                      ((shiftselection_In == 2'b10) || (shiftselection_In == 2'b01));
  assign terminal   = clear_InLow && !upcount_InLow && (cnt_q == CNT_LAST);

  always_comb begin
    lane_d = lane_q;
    if (!clear_InLow) begin
      lane_d = INIT_PATTERN;
    end else if (!load_InLow) begin
      lane_d = data_In;
    end else begin
      case (shiftselection_In)
        2'b10:   lane_d = {lane_q[DATAWIDTH-2:0], lane_q[DATAWIDTH-1]};
        2'b01:   lane_d = {lane_q[0], lane_q[DATAWIDTH-1:1]};
        default: lane_d = lane_q;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (!clear_InLow) begin
      last_d = '0;
    end else if (!loadLastRegister_InLow) begin
      last_d = lane_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!clear_InLow) begin
      cnt_d = '0;
    end else if (!upcount_InLow) begin
      cnt_d = terminal ? '0 : cnt_q + CNT_ONE;
    end
  end

  // A new tick outranks a shift that would consume the previous one on the same edge.
  always_comb begin
    t0_d = t0_q;
    if (!clear_InLow) begin
      t0_d = T0_IDLE;
    end else if (terminal) begin
      t0_d = T0_PENDING;
    end else if ((t0_q == T0_PENDING) && shift_done) begin
      t0_d = T0_IDLE;
    end
  end

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      lane_q <= INIT_PATTERN;
      last_q <= '0;
      cnt_q  <= '0;
      t0_q   <= T0_IDLE;
    end else begin
      lane_q <= lane_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      t0_q   <= t0_d;
    end
  end

  assign lane_Out         = lane_q;
  assign lastRegister_Out = last_q;
  assign T0_OutLow        = t0_q;

endmodule
